// File: rtl/dmem_responder.sv
// Data-memory responder for a RISC-V memory stage: accepts one load/store at a
// time, waits LATENCY cycles, then pulses resp_done with the extended load data.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_op,
  output logic        req_ready,
  output logic        resp_done,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] BYTE_CAP = 34'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            cap_write;
  logic            cap_err;
  logic [AW-1:0]   cap_idx;
  logic [1:0]      cap_lane;
  logic [31:0]     cap_wdata;
  logic [2:0]      cap_op;
  logic            do_access;
  logic            mem_we;
  logic [31:0]     rd_word;
  logic [31:0]     wr_bits;
  logic [31:0]     wr_data;
  logic [3:0]      wr_mask;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic req_is_bad(input logic wr, input logic [31:0] addr,
                                      input logic [2:0] op);
    logic bad;
    case (op)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = addr[0];
      3'b010:         bad = |addr[1:0];
      default:        bad = 1'b1;
    endcase
    if (wr && op[2]) bad = 1'b1;
    if ({2'b00, addr} >= BYTE_CAP) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] lane);
    case (op[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] wdata);
    case (op[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    resp_done = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: if (cnt == 4'd0) state_nxt = RESP;
      RESP: begin
        resp_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign do_access = (state == ACCESS) && (cnt == 4'd0);
  assign mem_we    = do_access && cap_write && !cap_err;
  assign rd_word   = mem[cap_idx];
  assign wr_mask   = lane_mask(cap_op, cap_lane);
  assign wr_data   = store_lanes(cap_op, cap_wdata);
  assign wr_bits   = {{8{wr_mask[3]}}, {8{wr_mask[2]}}, {8{wr_mask[1]}}, {8{wr_mask[0]}}};

  // Capture stage: request is frozen at acceptance; later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_write  <= 1'b0;
      cap_err    <= 1'b0;
      cap_idx    <= '0;
      cap_lane   <= 2'b00;
      cap_wdata  <= 32'h0;
      cap_op     <= 3'b000;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        cnt       <= CNT_INIT;
        cap_write <= req_write;
        cap_err   <= req_is_bad(req_write, req_addr, req_op);
        cap_idx   <= req_addr[AW+1:2];
        cap_lane  <= req_addr[1:0];
        cap_wdata <= req_wdata;
        cap_op    <= req_op;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        resp_error <= cap_err;
        resp_rdata <= (cap_err || cap_write) ? 32'h0 : load_extract(rd_word, cap_lane, cap_op);
      end
    end
  end

  // Storage stage: read-modify-write of the addressed word, untouched by reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[cap_idx] <= (rd_word & ~wr_bits) | (wr_data & wr_bits);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a byte-array
// reference model of load/store semantics and request timing.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_op;
  logic        req_ready;
  logic        resp_done;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_model [DEPTH*4];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  op;
    logic        chk;
    logic [31:0] rd;
    logic        err;
  } row_t;

  row_t tbl [15];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_op(req_op),
    .req_ready(req_ready), .resp_done(resp_done), .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: byte-addressed memory, error rules and extension from the load/store definitions
  function automatic void model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                       input logic [2:0] op, output logic [31:0] rd,
                                       output logic err);
    int size;
    logic [31:0] v;
    size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    err = (op == 3'd3) || (op == 3'd6) || (op == 3'd7) || (w && op[2]) ||
          (a % size != 0) || (a >= DEPTH * 4);
    rd = 32'h0;
    if (err) return;
    if (w) begin
      for (int k = 0; k < size; k++) mem_model[a + k] = d[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < size; k++) v = v | (32'(mem_model[a + k]) << (8 * k));
      if (op == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
      if (op == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      rd = v;
    end
  endfunction

  // Drive one request, then scramble the inputs so only the captured copy can matter.
  task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] op, output logic [31:0] rd, output logic e,
                          output int lat, output logic clean_end);
    int k;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_op = op;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_op = 3'($urandom);
    k = 0;
    while (!resp_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    lat = resp_done ? k - 1 : -1;
    rd  = resp_rdata;
    e   = resp_error;
    @(negedge clk);
    clean_end = !resp_done && req_ready && (resp_rdata === rd) && (resp_error === e);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_op = 3'b010;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({resp_done, resp_error, resp_rdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: done=%b err=%b rdata=%h required 0/0/00000000",
               resp_done, resp_error, resp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || resp_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b done=%b required 1/0", req_ready, resp_done);
    end
  endtask

  task automatic test_preload;
    logic [31:0] rd, exp_rd, d;
    logic e, exp_e, ok;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      transact(1'b1, 32'(i * 4), d, 3'b010, rd, e, lat, ok);
      model_access(1'b1, 32'(i * 4), d, 3'b010, exp_rd, exp_e);
      n_tests++;
      if (rd !== exp_rd || e !== exp_e || lat != LAT) begin
        n_fail++;
        $display("FAIL preload[%0d]: rdata=%h err=%b lat=%0d required %h/%b/%0d",
                 i, rd, e, lat, exp_rd, exp_e, LAT);
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] rd, exp_rd;
    logic e, exp_e, ok;
    int lat;
    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 1'b1, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        3'b010, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h13,  32'h80,       3'b000, 1'b1, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h13,  32'h0,        3'b000, 1'b1, 32'hFFFFFF80, 1'b0};
    tbl[4]  = '{1'b0, 32'h13,  32'h0,        3'b100, 1'b1, 32'h00000080, 1'b0};
    tbl[5]  = '{1'b0, 32'h10,  32'h0,        3'b010, 1'b1, 32'h80ADBEEF, 1'b0};
    tbl[6]  = '{1'b1, 32'h12,  32'h1234,     3'b001, 1'b1, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 32'h12,  32'h0,        3'b101, 1'b1, 32'h00001234, 1'b0};
    tbl[8]  = '{1'b0, 32'h11,  32'h0,        3'b001, 1'b1, 32'h0,        1'b1};
    tbl[9]  = '{1'b1, 32'h400, 32'h1,        3'b010, 1'b1, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 32'h400, 32'h0,        3'b010, 1'b1, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 32'h0,   32'h0,        3'b010, 1'b0, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 32'h10,  32'h0,        3'b011, 1'b1, 32'h0,        1'b1};
    tbl[13] = '{1'b1, 32'h14,  32'h55,       3'b100, 1'b1, 32'h0,        1'b1};
    tbl[14] = '{1'b0, 32'h12,  32'h0,        3'b010, 1'b1, 32'h0,        1'b1};
    for (int i = 0; i < 15; i++) begin
      transact(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].op, rd, e, lat, ok);
      model_access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].op, exp_rd, exp_e);
      if (tbl[i].chk) begin
        exp_rd = tbl[i].rd;
        exp_e  = tbl[i].err;
      end
      n_tests++;
      if (rd !== exp_rd || e !== exp_e) begin
        n_fail++;
        $display("FAIL directed[%0d]_data: rdata=%h err=%b required %h/%b", i, rd, e, exp_rd, exp_e);
      end
      n_tests++;
      if (lat != LAT || !ok) begin
        n_fail++;
        $display("FAIL directed[%0d]_timing: latency=%0d one_cycle_pulse=%b required %0d/1",
                 i, lat, ok, LAT);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, exp_rd, a, d;
    logic e, exp_e, ok, w;
    logic [2:0] op;
    int lat;
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 40));
      d  = $urandom;
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      transact(w, a, d, op, rd, e, lat, ok);
      model_access(w, a, d, op, exp_rd, exp_e);
      n_tests++;
      if (rd !== exp_rd || e !== exp_e) begin
        n_fail++;
        $display("FAIL random[%0d]_data w=%b a=%h op=%0d: rdata=%h err=%b required %h/%b",
                 i, w, a, op, rd, e, exp_rd, exp_e);
      end
      n_tests++;
      if (lat != LAT || !ok) begin
        n_fail++;
        $display("FAIL random[%0d]_timing: latency=%0d one_cycle_pulse=%b required %0d/1",
                 i, lat, ok, LAT);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd;
    logic exp_e, exp_ready, exp_done;
    model_access(1'b0, 32'h10, 32'h0, 3'b010, exp_rd, exp_e);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_op = 3'b010;
    for (int c = 0; c < 24; c++) begin
      exp_ready = (c % (LAT + 2)) == 0;
      exp_done  = (c % (LAT + 2)) == (LAT + 1);
      n_tests++;
      if (req_ready !== exp_ready || resp_done !== exp_done ||
          (exp_done && (resp_rdata !== exp_rd || resp_error !== exp_e))) begin
        n_fail++;
        $display("FAIL back_to_back[c=%0d]: ready=%b done=%b rdata=%h err=%b required %b/%b/%h/%b",
                 c, req_ready, resp_done, resp_rdata, resp_error, exp_ready, exp_done, exp_rd, exp_e);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, exp_rd;
    logic e, exp_e, ok;
    int lat;
    int seen;
    transact(1'b0, 32'h10, 32'h0, 3'b010, rd, e, lat, ok);
    model_access(1'b0, 32'h10, 32'h0, 3'b010, exp_rd, exp_e);
    n_tests++;
    if (rd !== exp_rd || rd === 32'h0) begin
      n_fail++;
      $display("FAIL abort_preload: rdata=%h required %h (nonzero)", rd, exp_rd);
    end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h5; req_op = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({resp_done, resp_error, resp_rdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL abort_async_clear: done=%b err=%b rdata=%h required 0/0/00000000",
               resp_done, resp_error, resp_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_done) seen++;
    end
    n_tests++;
    if (seen != 0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_no_done: done_pulses=%0d ready=%b rdata=%h required 0/1/00000000",
               seen, req_ready, resp_rdata);
    end
    transact(1'b0, 32'h20, 32'h0, 3'b010, rd, e, lat, ok);
    model_access(1'b0, 32'h20, 32'h0, 3'b010, exp_rd, exp_e);
    n_tests++;
    if (rd !== exp_rd || e !== exp_e || lat != LAT) begin
      n_fail++;
      $display("FAIL abort_storage_kept: rdata=%h err=%b lat=%0d required %h/%b/%0d",
               rd, e, lat, exp_rd, exp_e, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
